// File: rtl/car_power_state_reg.sv
// Power flag, button debounce and committed drive state for manual mode.
// Short press powers on, long press / stall / idle timeout powers off.
module car_power_state_reg #(
    parameter int DEBOUNCE_CYCLES   = 2_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int IDLE_TIMEOUT      = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic [1:0] next_state,
    input  logic [3:0] next_moving_state,
    input  logic       manual_power,
    output logic       power,
    output logic [1:0] state,
    output logic [3:0] moving_state,
    output logic [1:0] off_cause
);

    localparam int DB_W   = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
    localparam int HOLD_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam int IDLE_W = (IDLE_TIMEOUT      > 1) ? $clog2(IDLE_TIMEOUT)      : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] NSTART      = 2'b00;
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_STALL = 2'b01;
    localparam logic [1:0] CAUSE_IDLE  = 2'b10;
    localparam logic [1:0] CAUSE_LONG  = 2'b11;

    typedef enum logic [1:0] {
        P_OFF,
        P_ON_HELD,
        P_ON,
        P_OFF_HELD
    } pstate_t;

    pstate_t           r_pstate;
    logic              r_sync1;
    logic              r_sync2;
    logic [DB_W-1:0]   r_db_cnt;
    logic              r_btn_db;
    logic              r_btn_prev;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_power;
    logic [1:0]        r_state;
    logic [3:0]        r_moving;
    logic [1:0]        r_off_cause;

    logic w_rise;
    logic w_idle;
    logic w_long_hit;
    logic w_idle_hit;

    assign w_rise     = r_btn_db & ~r_btn_prev;
    assign w_idle     = (r_state == NSTART) & (next_state == NSTART) & ~r_btn_db;
    assign w_long_hit = r_btn_db & (r_hold_cnt == HOLD_LAST);
    assign w_idle_hit = w_idle & (r_idle_cnt == IDLE_LAST);

    // Two-flop synchronizer feeding a consecutive-sample debounce counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b0;
            r_btn_prev <= 1'b0;
        end else begin
            r_sync1    <= power_btn;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_btn_db;
            if (r_sync2 != r_btn_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_btn_db <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Drive state only tracks upstream while power stays on across the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pstate    <= P_OFF;
            r_power     <= 1'b0;
            r_state     <= NSTART;
            r_moving    <= 4'b0000;
            r_off_cause <= CAUSE_NONE;
            r_hold_cnt  <= '0;
            r_idle_cnt  <= '0;
        end else begin
            r_state    <= NSTART;
            r_moving   <= 4'b0000;
            r_hold_cnt <= '0;
            r_idle_cnt <= '0;
            unique case (r_pstate)
                P_OFF: begin
                    if (w_rise) begin
                        r_pstate    <= P_ON_HELD;
                        r_power     <= 1'b1;
                        r_off_cause <= CAUSE_NONE;
                    end
                end
                P_ON_HELD: begin
                    if (!manual_power) begin
                        r_pstate    <= P_OFF;
                        r_power     <= 1'b0;
                        r_off_cause <= CAUSE_STALL;
                    end else begin
                        r_state  <= next_state;
                        r_moving <= next_moving_state;
                        if (!r_btn_db) begin
                            r_pstate <= P_ON;
                        end
                    end
                end
                P_ON: begin
                    if (w_long_hit) begin
                        r_pstate    <= P_OFF_HELD;
                        r_power     <= 1'b0;
                        r_off_cause <= CAUSE_LONG;
                    end else if (!manual_power) begin
                        r_pstate    <= P_OFF;
                        r_power     <= 1'b0;
                        r_off_cause <= CAUSE_STALL;
                    end else if (w_idle_hit) begin
                        r_pstate    <= P_OFF;
                        r_power     <= 1'b0;
                        r_off_cause <= CAUSE_IDLE;
                    end else begin
                        r_state  <= next_state;
                        r_moving <= next_moving_state;
                        if (r_btn_db && r_hold_cnt != HOLD_LAST) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                        if (w_idle && r_idle_cnt != IDLE_LAST) begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                P_OFF_HELD: begin
                    if (!r_btn_db) begin
                        r_pstate <= P_OFF;
                    end
                end
                default: begin
                    r_pstate <= P_OFF;
                    r_power  <= 1'b0;
                end
            endcase
        end
    end

    assign power        = r_power;
    assign state        = r_state;
    assign moving_state = r_moving;
    assign off_cause    = r_off_cause;

endmodule

// File: tb/tb_car_power_state_reg.sv
// Scoreboard bench for car_power_state_reg with short debounce/press/idle
// parameters; outputs packed as {power, state, moving_state, off_cause}.
module tb_car_power_state_reg;

    logic       clk;
    logic       rst;
    logic       power_btn;
    logic [1:0] next_state;
    logic [3:0] next_moving_state;
    logic       manual_power;
    logic       power;
    logic [1:0] state;
    logic [3:0] moving_state;
    logic [1:0] off_cause;

    car_power_state_reg #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(8),
        .IDLE_TIMEOUT     (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .power_btn        (power_btn),
        .next_state       (next_state),
        .next_moving_state(next_moving_state),
        .manual_power     (manual_power),
        .power            (power),
        .state            (state),
        .moving_state     (moving_state),
        .off_cause        (off_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [8:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_chk = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b (power,state,moving,cause)", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [8:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic sb_cmp();
        sb_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sb_empty got=none exp=entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, {power, state, moving_state, off_cause}, e.exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] pk(input logic p, input logic [1:0] s,
                                      input logic [3:0] m, input logic [1:0] c);
        return {p, s, m, c};
    endfunction

    // Press 10 cycles, release, and land in P_ON (7 edges after release).
    task automatic power_on(input string nm, input logic [1:0] ns,
                            input logic [3:0] nmv, input logic [1:0] pc);
        next_state        = ns;
        next_moving_state = nmv;
        manual_power      = 1'b1;
        power_btn         = 1'b1;
        push({nm, "_pre"}, pk(1'b0, 2'b00, 4'b0000, pc));
        tick(6);
        sb_cmp();
        push({nm, "_on"}, pk(1'b1, 2'b00, 4'b0000, 2'b00));
        tick(1);
        sb_cmp();
        push({nm, "_follow"}, pk(1'b1, ns, nmv, 2'b00));
        tick(1);
        sb_cmp();
        tick(2);
        power_btn = 1'b0;
        push({nm, "_rel"}, pk(1'b1, ns, nmv, 2'b00));
        tick(7);
        sb_cmp();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        power_btn         = 1'b0;
        next_state        = 2'b00;
        next_moving_state = 4'b0000;
        manual_power      = 1'b1;
        tick(3);
        push("reset", pk(1'b0, 2'b00, 4'b0000, 2'b00));
        sb_cmp();
        rst = 1'b0;

        // Bounce pulses of 1..3 cycles never reach the debounce threshold
        for (int w = 1; w <= 3; w++) begin
            power_btn = 1'b1;
            tick(w);
            power_btn = 1'b0;
            push($sformatf("bounce%0d", w), pk(1'b0, 2'b00, 4'b0000, 2'b00));
            tick(8);
            sb_cmp();
        end

        power_on("pon1", 2'b01, 4'b0001, 2'b00);

        next_state        = 2'b10;
        next_moving_state = 4'b0100;
        push("moving", pk(1'b1, 2'b10, 4'b0100, 2'b00));
        tick(1);
        sb_cmp();
        manual_power = 1'b0;
        push("stall", pk(1'b0, 2'b00, 4'b0000, 2'b01));
        tick(1);
        sb_cmp();
        manual_power = 1'b1;
        tick(2);

        power_on("pon2", 2'b00, 4'b0000, 2'b01);
        push("idle_pre", pk(1'b1, 2'b00, 4'b0000, 2'b00));
        tick(15);
        sb_cmp();
        push("idle_off", pk(1'b0, 2'b00, 4'b0000, 2'b10));
        tick(1);
        sb_cmp();

        power_on("pon3", 2'b00, 4'b0000, 2'b10);
        tick(10);
        next_state = 2'b01;
        push("idle_brk", pk(1'b1, 2'b01, 4'b0000, 2'b00));
        tick(1);
        sb_cmp();
        next_state = 2'b00;
        tick(1);
        push("idle_rst", pk(1'b1, 2'b00, 4'b0000, 2'b00));
        tick(15);
        sb_cmp();
        push("idle_off2", pk(1'b0, 2'b00, 4'b0000, 2'b10));
        tick(1);
        sb_cmp();

        power_on("pon4", 2'b01, 4'b0010, 2'b10);
        power_btn = 1'b1;
        push("long_pre", pk(1'b1, 2'b01, 4'b0010, 2'b00));
        tick(13);
        sb_cmp();
        push("long_off", pk(1'b0, 2'b00, 4'b0000, 2'b11));
        tick(1);
        sb_cmp();
        push("long_keep", pk(1'b0, 2'b00, 4'b0000, 2'b11));
        tick(20);
        sb_cmp();
        power_btn = 1'b0;
        push("long_rel", pk(1'b0, 2'b00, 4'b0000, 2'b11));
        tick(10);
        sb_cmp();

        power_on("pon5", 2'b01, 4'b1000, 2'b11);
        power_btn = 1'b1;
        tick(13);
        manual_power = 1'b0;
        push("long_vs_stall", pk(1'b0, 2'b00, 4'b0000, 2'b11));
        tick(1);
        sb_cmp();
        manual_power = 1'b1;
        tick(5);
        power_btn = 1'b0;
        tick(10);

        power_on("pon6", 2'b10, 4'b1000, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        push("async_rst", pk(1'b0, 2'b00, 4'b0000, 2'b00));
        sb_cmp();
        tick(1);
        rst = 1'b0;
        power_on("pon7", 2'b01, 4'b0001, 2'b00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
